cpu_sequencer: RTL and testbench
================================

# cpu_sequencer

Multi-cycle control FSM for the MIPS CPU datapath. It sequences instruction fetch, decode, execute, memory access and write-back by driving datapath enables and mux selects from the latched opcode/funct. It stalls on a ready handshake from instruction/data memory, and traps to a sticky fault state on illegal instructions or memory timeout. It sits between the CPU datapath (register file, ALU, PC, IR) and the shared memory port.

## Interface
Parameters:
- MEM_TIMEOUT, 15: max wait cycles for mem_ready before FAULT (counter width = $clog2(MEM_TIMEOUT+1)).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes current read/write this cycle
- pc_we  out  1  load PC
- pc_src  out  2  0=ALU result (PC+4), 1=ALUOut (branch target), 2=jump {PC[31:28],IR[25:0],2'b00}, 3=rs value
- ir_we  out  1  load IR
- iord  out  1  memory address: 0=PC, 1=ALUOut
- mem_read, mem_write  out  1 each  memory strobes
- reg_we  out  1  register file write
- reg_dst  out  2  0=rt, 1=rd, 2=$31
- mem_to_reg  out  2  0=ALUOut, 1=MDR, 2=PC
- alu_src_a  out  1  0=PC, 1=rs
- alu_src_b  out  2  0=rt, 1=const 4, 2=sign-ext imm, 3=sign-ext imm<<2 (XORI uses 2 with zero-extend flag)
- zext  out  1  zero-extend immediate
- alu_op  out  2  0=ADD, 1=SUB, 2=XOR, 3=SLT
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction
- fault  out  1  sticky error
- state  out  4  current state, debug

## Operation
- Supported: LW 0x23, SW 0x2B, J 0x02, JAL 0x03, BNE 0x05, XORI 0x0E, R-type 0x00 with funct ADD 0x20, SUB 0x22, SLT 0x2A, JR 0x08. Anything else is illegal.
- States: FETCH, DECODE, EX_MEMADDR, MEM_RD, MEM_WR, WB_MEM, EX_R, WB_R, EX_XORI, WB_I, EX_BNE, EX_J, EX_JAL, EX_JR, FAULT.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=1, ADD. Wait while !mem_ready. On mem_ready: ir_we=1, pc_we=1, pc_src=0, then go to DECODE.
- DECODE: ALUOut <= PC + (imm<<2), using alu_src_b=3. Dispatch on class. Illegal goes to FAULT.
- LW: EX_MEMADDR (rs+imm) -> MEM_RD (iord=1, mem_read, wait for ready) -> WB_MEM (reg_we, reg_dst=0, mem_to_reg=1).
- SW: EX_MEMADDR -> MEM_WR (iord=1, mem_write, wait for ready; completes on ready).
- R-type: EX_R (rs op rt; alu_op from funct) -> WB_R (reg_dst=1, mem_to_reg=0).
- XORI: EX_XORI (zext=1, alu_src_b=2, XOR) -> WB_I (reg_dst=0).
- BNE: EX_BNE (SUB rs,rt); pc_we = !zero, pc_src=1.
- J: pc_we, pc_src=2.
- JAL: pc_we, pc_src=2, reg_we, reg_dst=2, mem_to_reg=2. PC already holds PC+4, so $31 = return address.
- JR: pc_we, pc_src=3.
- The last state of every instruction asserts instr_done and returns to FETCH.
- Wait counter: cleared on entry to FETCH/MEM_RD/MEM_WR; increments each cycle mem_ready=0. If it reaches MEM_TIMEOUT with mem_ready still 0, go to FAULT.
- FAULT: all strobes 0, fault=1. Leaves only on reset.

## Timing
- Reset (sync): next edge gives state=FETCH, counter=0, fault=0. During a reset-asserted cycle, all write/strobe outputs are forced to 0. Reset mid-instruction aborts it with no write.
- Outputs are Moore-decoded from state, except that FETCH ir_we/pc_we, MEM_RD/MEM_WR completion and BNE pc_we are qualified combinationally by mem_ready/zero.
- Latency with mem_ready tied high: J/JAL/JR/BNE 3 cycles, R-type/XORI/SW 4, LW 5. Each mem_ready=0 cycle in a memory state adds one cycle.
- mem_ready asserted in the same cycle the counter hits MEM_TIMEOUT: completion wins, no fault.
- mem_ready outside memory states is ignored.

## Structure
- Package cpu_ctrl_pkg holds opcode/funct constants, the state enum, alu_op codes, and pc_src/reg_dst/mem_to_reg/alu_src_b select codes.
- Sub-module instr_class_decode (combinational): opcode+funct -> {RTYPE_ADD, RTYPE_SUB, RTYPE_SLT, JR, LW, SW, BNE, XORI, J, JAL, ILLEGAL}.
- FSM, wait counter and output decode live in cpu_sequencer.

## Test plan
- Reset then J (opcode 0x02), mem_ready=1 -> states FETCH, DECODE, EX_J; pc_we with pc_src=2 in cycle 3; instr_done pulses once.
- LW with mem_ready low 2 cycles in MEM_RD -> 7 cycles total; reg_we=1 only in WB_MEM with reg_dst=0, mem_to_reg=1.
- BNE with zero=1 -> no pc_we in EX_BNE. Repeat with zero=0 -> pc_we=1, pc_src=1.
- R-type funct 0x22 -> alu_op=1 in EX_R, reg_dst=1 in WB_R. Funct 0x2A -> alu_op=3. Funct 0x21 -> FAULT after DECODE.
- MEM_TIMEOUT=15, mem_ready held 0 in FETCH -> fault=1 after 15 wait cycles, all strobes 0. Reset -> FETCH, fault=0.
- JAL then reset asserted mid-EX_JAL -> no reg_we that cycle; next state is FETCH.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: opcodes, functs,
// sequencer states, instruction classes and datapath select codes.
package cpu_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [3:0] {
        ST_FETCH      = 4'd0,
        ST_DECODE     = 4'd1,
        ST_EX_MEMADDR = 4'd2,
        ST_MEM_RD     = 4'd3,
        ST_MEM_WR     = 4'd4,
        ST_WB_MEM     = 4'd5,
        ST_EX_R       = 4'd6,
        ST_WB_R       = 4'd7,
        ST_EX_XORI    = 4'd8,
        ST_WB_I       = 4'd9,
        ST_EX_BNE     = 4'd10,
        ST_EX_J       = 4'd11,
        ST_EX_JAL     = 4'd12,
        ST_EX_JR      = 4'd13,
        ST_FAULT      = 4'd14
    } stateT;

    typedef enum logic [3:0] {
        CLS_RADD    = 4'd0,
        CLS_RSUB    = 4'd1,
        CLS_RSLT    = 4'd2,
        CLS_JR      = 4'd3,
        CLS_LW      = 4'd4,
        CLS_SW      = 4'd5,
        CLS_BNE     = 4'd6,
        CLS_XORI    = 4'd7,
        CLS_J       = 4'd8,
        CLS_JAL     = 4'd9,
        CLS_ILLEGAL = 4'd10
    } instrClassT;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_XOR = 2'd2;
    localparam logic [1:0] ALU_SLT = 2'd3;

    localparam logic [1:0] PC_SRC_SEQ  = 2'd0;
    localparam logic [1:0] PC_SRC_BR   = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP = 2'd2;
    localparam logic [1:0] PC_SRC_RS   = 2'd3;

    localparam logic [1:0] REG_DST_RT = 2'd0;
    localparam logic [1:0] REG_DST_RD = 2'd1;
    localparam logic [1:0] REG_DST_RA = 2'd2;

    localparam logic [1:0] MEM_TO_REG_ALU = 2'd0;
    localparam logic [1:0] MEM_TO_REG_MDR = 2'd1;
    localparam logic [1:0] MEM_TO_REG_PC  = 2'd2;

    localparam logic ALU_A_PC = 1'b0;
    localparam logic ALU_A_RS = 1'b1;

    localparam logic [1:0] ALU_B_RT      = 2'd0;
    localparam logic [1:0] ALU_B_FOUR    = 2'd1;
    localparam logic [1:0] ALU_B_IMM     = 2'd2;
    localparam logic [1:0] ALU_B_IMM_SH2 = 2'd3;

    function automatic logic [1:0] rTypeAluOp(input instrClassT cls);
        case (cls)
            CLS_RSUB: rTypeAluOp = ALU_SUB;
            CLS_RSLT: rTypeAluOp = ALU_SLT;
            default:  rTypeAluOp = ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/instr_class_decode.sv
// Combinational opcode/funct classifier; anything unsupported maps to CLS_ILLEGAL.
module instr_class_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [3:0] instrClass
);

    instrClassT cls;

    always_comb begin
        cls = CLS_ILLEGAL;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  cls = CLS_RADD;
                    FN_SUB:  cls = CLS_RSUB;
                    FN_SLT:  cls = CLS_RSLT;
                    FN_JR:   cls = CLS_JR;
                    default: cls = CLS_ILLEGAL;
                endcase
            end
            OP_LW:   cls = CLS_LW;
            OP_SW:   cls = CLS_SW;
            OP_BNE:  cls = CLS_BNE;
            OP_XORI: cls = CLS_XORI;
            OP_J:    cls = CLS_J;
            OP_JAL:  cls = CLS_JAL;
            default: cls = CLS_ILLEGAL;
        endcase
    end

    assign instrClass = cls;

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/mem/write-back,
// stalls on mem_ready with a bounded wait, and traps to a sticky FAULT state.
module cpu_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic       ir_we,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_we,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       zext,
    output logic [1:0] alu_op,
    output logic       instr_done,
    output logic       fault,
    output logic [3:0] state
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MEM_TIMEOUT - 1);

    stateT            curState;
    instrClassT       latchedClass;
    instrClassT       decodedClass;
    logic [3:0]       decodedRaw;
    logic [CNT_W-1:0] waitCnt;

    instr_class_decode uDecode (
        .opcode     (opcode),
        .funct      (funct),
        .instrClass (decodedRaw)
    );

    assign decodedClass = instrClassT'(decodedRaw);
    assign state        = curState;

    // waitCnt only survives across self-loops of a wait state, so every entry starts from 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            curState     <= ST_FETCH;
            waitCnt      <= '0;
            latchedClass <= CLS_ILLEGAL;
        end else begin
            waitCnt <= '0;
            case (curState)
                ST_FETCH: begin
                    if (mem_ready)                curState <= ST_DECODE;
                    else if (waitCnt == LAST_WAIT) curState <= ST_FAULT;
                    else                          waitCnt  <= waitCnt + 1'b1;
                end
                ST_DECODE: begin
                    latchedClass <= decodedClass;
                    case (decodedClass)
                        CLS_LW, CLS_SW:               curState <= ST_EX_MEMADDR;
                        CLS_RADD, CLS_RSUB, CLS_RSLT: curState <= ST_EX_R;
                        CLS_XORI:                     curState <= ST_EX_XORI;
                        CLS_BNE:                      curState <= ST_EX_BNE;
                        CLS_J:                        curState <= ST_EX_J;
                        CLS_JAL:                      curState <= ST_EX_JAL;
                        CLS_JR:                       curState <= ST_EX_JR;
                        default:                      curState <= ST_FAULT;
                    endcase
                end
                ST_EX_MEMADDR: begin
                    if (latchedClass == CLS_LW) curState <= ST_MEM_RD;
                    else                        curState <= ST_MEM_WR;
                end
                ST_MEM_RD: begin
                    if (mem_ready)                curState <= ST_WB_MEM;
                    else if (waitCnt == LAST_WAIT) curState <= ST_FAULT;
                    else                          waitCnt  <= waitCnt + 1'b1;
                end
                ST_MEM_WR: begin
                    if (mem_ready)                curState <= ST_FETCH;
                    else if (waitCnt == LAST_WAIT) curState <= ST_FAULT;
                    else                          waitCnt  <= waitCnt + 1'b1;
                end
                ST_EX_R:    curState <= ST_WB_R;
                ST_EX_XORI: curState <= ST_WB_I;
                ST_WB_MEM, ST_WB_R, ST_WB_I, ST_EX_BNE,
                ST_EX_J, ST_EX_JAL, ST_EX_JR:
                            curState <= ST_FETCH;
                ST_FAULT:   curState <= ST_FAULT;
                default:    curState <= ST_FAULT;
            endcase
        end
    end

    always_comb begin
        pc_we      = 1'b0;
        pc_src     = PC_SRC_SEQ;
        ir_we      = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_we     = 1'b0;
        reg_dst    = REG_DST_RT;
        mem_to_reg = MEM_TO_REG_ALU;
        alu_src_a  = ALU_A_PC;
        alu_src_b  = ALU_B_RT;
        zext       = 1'b0;
        alu_op     = ALU_ADD;
        instr_done = 1'b0;
        fault      = 1'b0;
        case (curState)
            ST_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = ALU_B_FOUR;
                ir_we     = mem_ready;
                pc_we     = mem_ready;
            end
            ST_DECODE: alu_src_b = ALU_B_IMM_SH2;
            ST_EX_MEMADDR: begin
                alu_src_a = ALU_A_RS;
                alu_src_b = ALU_B_IMM;
            end
            ST_MEM_RD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
            end
            ST_MEM_WR: begin
                iord       = 1'b1;
                mem_write  = 1'b1;
                instr_done = mem_ready;
            end
            ST_WB_MEM: begin
                reg_we     = 1'b1;
                mem_to_reg = MEM_TO_REG_MDR;
                instr_done = 1'b1;
            end
            ST_EX_R: begin
                alu_src_a = ALU_A_RS;
                alu_op    = rTypeAluOp(latchedClass);
            end
            ST_WB_R: begin
                reg_we     = 1'b1;
                reg_dst    = REG_DST_RD;
                instr_done = 1'b1;
            end
            ST_EX_XORI: begin
                alu_src_a = ALU_A_RS;
                alu_src_b = ALU_B_IMM;
                zext      = 1'b1;
                alu_op    = ALU_XOR;
            end
            ST_WB_I: begin
                reg_we     = 1'b1;
                instr_done = 1'b1;
            end
            ST_EX_BNE: begin
                alu_src_a  = ALU_A_RS;
                alu_op     = ALU_SUB;
                pc_src     = PC_SRC_BR;
                pc_we      = !zero;
                instr_done = 1'b1;
            end
            ST_EX_J: begin
                pc_we      = 1'b1;
                pc_src     = PC_SRC_JUMP;
                instr_done = 1'b1;
            end
            ST_EX_JAL: begin
                pc_we      = 1'b1;
                pc_src     = PC_SRC_JUMP;
                reg_we     = 1'b1;
                reg_dst    = REG_DST_RA;
                mem_to_reg = MEM_TO_REG_PC;
                instr_done = 1'b1;
            end
            ST_EX_JR: begin
                pc_we      = 1'b1;
                pc_src     = PC_SRC_RS;
                instr_done = 1'b1;
            end
            ST_FAULT: fault = 1'b1;
            default:  fault = 1'b1;
        endcase
        // A reset cycle must never commit architectural state, whatever the current state.
        if (reset) begin
            pc_we      = 1'b0;
            ir_we      = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            reg_we     = 1'b0;
            instr_done = 1'b0;
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed cycle-by-cycle bench for cpu_sequencer with hand-computed expectations.
module tb_cpu_sequencer;
    import cpu_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode, funct;
    logic       zero, mem_ready;
    logic       pc_we, ir_we, iord, mem_read, mem_write, reg_we;
    logic       alu_src_a, zext, instr_done, fault;
    logic [1:0] pc_src, reg_dst, mem_to_reg, alu_src_b, alu_op;
    logic [3:0] state;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cpu_sequencer #(.MEM_TIMEOUT(15)) dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_we      (pc_we),
        .pc_src     (pc_src),
        .ir_we      (ir_we),
        .iord       (iord),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .reg_we     (reg_we),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .zext       (zext),
        .alu_op     (alu_op),
        .instr_done (instr_done),
        .fault      (fault),
        .state      (state)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock, then apply this cycle's memory/zero inputs.
    task automatic step(input logic rdy, input logic z);
        @(posedge clk);
        #1;
        mem_ready = rdy;
        zero      = z;
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        reset = 1'b1; opcode = OP_J; funct = 6'h00; zero = 1'b0; mem_ready = 1'b0;
        step(1, 0);
        chk("rst_state", state, ST_FETCH);
        chk("rst_mem_read_gated", mem_read, 0);
        chk("rst_ir_we_gated", ir_we, 0);
        chk("rst_pc_we_gated", pc_we, 0);
        chk("rst_fault", fault, 0);

        // J: FETCH, DECODE, EX_J
        reset = 1'b0; #1;
        chk("j_fetch_ir_we", ir_we, 1);
        chk("j_fetch_pc_we", pc_we, 1);
        chk("j_fetch_pc_src", pc_src, 0);
        chk("j_fetch_alub", alu_src_b, 1);
        chk("j_fetch_done", instr_done, 0);
        step(1, 0);
        chk("j_dec_state", state, ST_DECODE);
        chk("j_dec_alub", alu_src_b, 3);
        chk("j_dec_pc_we", pc_we, 0);
        chk("j_dec_done", instr_done, 0);
        step(1, 0);
        chk("j_ex_state", state, ST_EX_J);
        chk("j_ex_pc_we", pc_we, 1);
        chk("j_ex_pc_src", pc_src, 2);
        chk("j_ex_done", instr_done, 1);
        step(1, 0);
        chk("j_next_state", state, ST_FETCH);
        chk("j_next_done", instr_done, 0);

        // LW with two not-ready cycles in MEM_RD: 7 cycles total
        opcode = OP_LW;
        chk("lw_c1_reg_we", reg_we, 0);
        step(1, 0);
        chk("lw_c2_state", state, ST_DECODE);
        step(1, 0);
        chk("lw_c3_state", state, ST_EX_MEMADDR);
        chk("lw_c3_alua", alu_src_a, 1);
        chk("lw_c3_alub", alu_src_b, 2);
        step(0, 0);
        chk("lw_c4_state", state, ST_MEM_RD);
        chk("lw_c4_iord", iord, 1);
        chk("lw_c4_mem_read", mem_read, 1);
        chk("lw_c4_reg_we", reg_we, 0);
        step(0, 0);
        chk("lw_c5_state", state, ST_MEM_RD);
        step(1, 0);
        chk("lw_c6_state", state, ST_MEM_RD);
        chk("lw_c6_done", instr_done, 0);
        step(1, 0);
        chk("lw_c7_state", state, ST_WB_MEM);
        chk("lw_c7_reg_we", reg_we, 1);
        chk("lw_c7_reg_dst", reg_dst, 0);
        chk("lw_c7_mem_to_reg", mem_to_reg, 1);
        chk("lw_c7_done", instr_done, 1);
        step(1, 0);
        chk("lw_next_state", state, ST_FETCH);

        // BNE taken/not taken
        opcode = OP_BNE;
        step(1, 1);
        step(1, 1);
        chk("bne_z1_state", state, ST_EX_BNE);
        chk("bne_z1_pc_we", pc_we, 0);
        chk("bne_z1_alu_op", alu_op, 1);
        chk("bne_z1_done", instr_done, 1);
        step(1, 0);
        step(1, 0);
        step(1, 0);
        chk("bne_z0_state", state, ST_EX_BNE);
        chk("bne_z0_pc_we", pc_we, 1);
        chk("bne_z0_pc_src", pc_src, 1);
        step(1, 0);

        // R-type SUB then SLT
        opcode = OP_RTYPE; funct = FN_SUB;
        step(1, 0);
        step(1, 0);
        chk("sub_ex_state", state, ST_EX_R);
        chk("sub_ex_alu_op", alu_op, 1);
        chk("sub_ex_alua", alu_src_a, 1);
        chk("sub_ex_alub", alu_src_b, 0);
        chk("sub_ex_reg_we", reg_we, 0);
        step(1, 0);
        chk("sub_wb_state", state, ST_WB_R);
        chk("sub_wb_reg_we", reg_we, 1);
        chk("sub_wb_reg_dst", reg_dst, 1);
        chk("sub_wb_mem_to_reg", mem_to_reg, 0);
        chk("sub_wb_done", instr_done, 1);
        step(1, 0);
        funct = FN_SLT;
        step(1, 0);
        step(1, 0);
        chk("slt_ex_alu_op", alu_op, 3);
        step(1, 0);
        step(1, 0);
        chk("slt_next_state", state, ST_FETCH);

        // XORI
        opcode = OP_XORI;
        step(1, 0);
        step(1, 0);
        chk("xori_ex_state", state, ST_EX_XORI);
        chk("xori_ex_zext", zext, 1);
        chk("xori_ex_alub", alu_src_b, 2);
        chk("xori_ex_alu_op", alu_op, 2);
        step(1, 0);
        chk("xori_wb_state", state, ST_WB_I);
        chk("xori_wb_reg_we", reg_we, 1);
        chk("xori_wb_reg_dst", reg_dst, 0);
        step(1, 0);

        // SW with one not-ready cycle
        opcode = OP_SW;
        step(1, 0);
        step(1, 0);
        step(0, 0);
        chk("sw_wr_state", state, ST_MEM_WR);
        chk("sw_wr_mem_write", mem_write, 1);
        chk("sw_wr_iord", iord, 1);
        chk("sw_wr_done_wait", instr_done, 0);
        step(1, 0);
        chk("sw_wr_done_ready", instr_done, 1);
        step(1, 0);
        chk("sw_next_state", state, ST_FETCH);
        chk("sw_next_mem_write", mem_write, 0);

        // JR
        opcode = OP_RTYPE; funct = FN_JR;
        step(1, 0);
        step(1, 0);
        chk("jr_state", state, ST_EX_JR);
        chk("jr_pc_src", pc_src, 3);
        chk("jr_pc_we", pc_we, 1);
        step(1, 0);

        // JAL, then reset mid-EX_JAL
        opcode = OP_JAL;
        step(1, 0);
        step(1, 0);
        chk("jal_state", state, ST_EX_JAL);
        chk("jal_reg_we", reg_we, 1);
        chk("jal_reg_dst", reg_dst, 2);
        chk("jal_mem_to_reg", mem_to_reg, 2);
        reset = 1'b1; #1;
        chk("jal_rst_reg_we", reg_we, 0);
        chk("jal_rst_pc_we", pc_we, 0);
        chk("jal_rst_done", instr_done, 0);
        step(1, 0);
        reset = 1'b0; #1;
        chk("jal_rst_next_state", state, ST_FETCH);

        // 14 not-ready FETCH cycles then ready on the 15th: completes; then illegal funct
        opcode = OP_RTYPE; funct = 6'h21;
        mem_ready = 1'b0; #1;
        chk("bnd_c1_ir_we", ir_we, 0);
        for (int i = 0; i < 13; i++) step(0, 0);
        chk("bnd_c14_state", state, ST_FETCH);
        step(1, 0);
        chk("bnd_c15_state", state, ST_FETCH);
        chk("bnd_c15_ir_we", ir_we, 1);
        step(1, 0);
        chk("ill_dec_state", state, ST_DECODE);
        step(1, 0);
        chk("ill_fault_state", state, ST_FAULT);
        chk("ill_fault", fault, 1);
        step(1, 0);
        chk("ill_sticky_state", state, ST_FAULT);
        chk("ill_sticky_mem_read", mem_read, 0);
        reset = 1'b1;
        step(1, 0);
        reset = 1'b0; #1;
        chk("ill_recover_state", state, ST_FETCH);
        chk("ill_recover_fault", fault, 0);

        // FETCH timeout: 15 not-ready cycles -> FAULT
        mem_ready = 1'b0; #1;
        for (int i = 0; i < 14; i++) step(0, 0);
        chk("to_c15_state", state, ST_FETCH);
        step(0, 0);
        chk("to_state", state, ST_FAULT);
        chk("to_fault", fault, 1);
        chk("to_mem_read", mem_read, 0);
        chk("to_pc_we", pc_we, 0);
        chk("to_ir_we", ir_we, 0);
        chk("to_reg_we", reg_we, 0);
        reset = 1'b1;
        step(0, 0);
        reset = 1'b0; #1;
        chk("to_recover_state", state, ST_FETCH);
        chk("to_recover_fault", fault, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
